// File: rtl/aes_selftest_seq.sv
// Built-in self-test sequencer: one encrypt-then-decrypt pass through the AES cores
// in a latched key-size mode, with pass/fail flags, done pulse and a pass counter.
module aes_selftest_seq #(
   parameter int DATA_W    = 128,
   parameter int LAT_EXTRA = 2,
   parameter int CNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] pt,
   input  logic [DATA_W-1:0] exp_ct,
   input  logic [DATA_W-1:0] enc_out,
   input  logic [DATA_W-1:0] dec_out,
   output logic              enc_en,
   output logic              dec_en,
   output logic [1:0]        core_sel,
   output logic [DATA_W-1:0] dec_in,
   output logic [3:0]        nr_out,
   output logic              busy,
   output logic              done,
   output logic              enc_ok,
   output logic              dec_ok,
   output logic              mode_err,
   output logic [CNT_W-1:0]  pass_cnt,
   output logic [7:0]        result_byte
);

   typedef enum logic [1:0] {IDLE, ENC, DEC, DONE} state_t;

   state_t            state, state_nxt;
   logic [4:0]        cnt;
   logic [4:0]        lat_last;
   logic [3:0]        nr_sel;
   logic [DATA_W-1:0] pt_lat;
   logic [DATA_W-1:0] ct_lat;
   logic              accept;
   logic              bad_req;
   logic              last_cycle;

   // Core latency is counted from the latched Nr so a mid-run mode change cannot stretch it
   assign lat_last   = 5'(nr_out) + 5'(LAT_EXTRA) - 5'd1;
   assign last_cycle = (cnt == lat_last);

   always_comb begin
      case (mode)
         2'b00:   nr_sel = 4'd10;
         2'b01:   nr_sel = 4'd12;
         default: nr_sel = 4'd14;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      enc_en    = 1'b0;
      dec_en    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      bad_req   = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               if (mode != 2'b11) begin
                  accept    = 1'b1;
                  state_nxt = ENC;
               end else begin
                  bad_req = 1'b1;
               end
            end
         end
         ENC: begin
            enc_en = 1'b1;
            busy   = 1'b1;
            if (abort)           state_nxt = IDLE;
            else if (last_cycle) state_nxt = DEC;
         end
         DEC: begin
            dec_en = 1'b1;
            busy   = 1'b1;
            if (abort)           state_nxt = IDLE;
            else if (last_cycle) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Plaintext and expected ciphertext are latched at start so board-side changes during a run are ignored
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         core_sel    <= '0;
         nr_out      <= '0;
         pt_lat      <= '0;
         ct_lat      <= '0;
         dec_in      <= '0;
         enc_ok      <= 1'b0;
         dec_ok      <= 1'b0;
         mode_err    <= 1'b0;
         pass_cnt    <= '0;
         result_byte <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  core_sel <= mode;
                  nr_out   <= nr_sel;
                  pt_lat   <= pt;
                  ct_lat   <= exp_ct;
                  enc_ok   <= 1'b0;
                  dec_ok   <= 1'b0;
                  mode_err <= 1'b0;
                  cnt      <= '0;
               end else if (bad_req) begin
                  mode_err <= 1'b1;
               end
            end
            ENC: begin
               if (abort) begin
                  enc_ok <= 1'b0;
                  dec_ok <= 1'b0;
                  cnt    <= '0;
               end else if (last_cycle) begin
                  dec_in      <= enc_out;
                  enc_ok      <= (enc_out == ct_lat);
                  result_byte <= enc_out[DATA_W-1 -: 8];
                  cnt         <= '0;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
            DEC: begin
               if (abort) begin
                  enc_ok <= 1'b0;
                  dec_ok <= 1'b0;
                  cnt    <= '0;
               end else if (last_cycle) begin
                  dec_ok      <= (dec_out == pt_lat);
                  result_byte <= dec_out[DATA_W-1 -: 8];
                  cnt         <= '0;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
            DONE: begin
               if (enc_ok && dec_ok) pass_cnt <= pass_cnt + 1'b1;
            end
            default: cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_selftest_seq.sv
// Self-checking bench for aes_selftest_seq: behavioural cipher/decipher core models
// plus per-scenario tasks comparing against run-level expectations.
module tb_aes_selftest_seq;

   localparam logic [127:0] VEC_PT = 128'h00112233445566778899aabbccddeeff;

   logic         clk = 1'b0;
   logic         rst_n, start, abort;
   logic [1:0]   mode;
   logic [127:0] pt, exp_ct, enc_out, dec_out;
   logic         enc_en, dec_en, busy, done, enc_ok, dec_ok, mode_err;
   logic [1:0]   core_sel;
   logic [127:0] dec_in;
   logic [3:0]   nr_out;
   logic [7:0]   pass_cnt, result_byte;

   int total = 0;
   int bad   = 0;
   int pass_model = 0;

   typedef struct packed {
      int         done_cyc;
      logic       ok_mid;
      logic [7:0] rb_mid;
      logic [1:0] sel_mid;
      logic       done_next;
      logic       busy_ab;
   } run_t;

   aes_selftest_seq #(.DATA_W(128), .LAT_EXTRA(2), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
      .pt(pt), .exp_ct(exp_ct), .enc_out(enc_out), .dec_out(dec_out),
      .enc_en(enc_en), .dec_en(dec_en), .core_sel(core_sel), .dec_in(dec_in),
      .nr_out(nr_out), .busy(busy), .done(done), .enc_ok(enc_ok), .dec_ok(dec_ok),
      .mode_err(mode_err), .pass_cnt(pass_cnt), .result_byte(result_byte)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] vec_ct(input logic [1:0] m);
      case (m)
         2'd0:    return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
         2'd1:    return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
         default: return 128'h8ea2b7ca516745bfeafc49904b496089;
      endcase
   endfunction

   // Toy involutive cipher that reproduces the FIPS-197 vectors for VEC_PT
   function automatic logic [127:0] cipher(input logic [127:0] p, input logic [1:0] m);
      return p ^ vec_ct(m) ^ VEC_PT;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Core models: output is valid only once enable has been held for the mode latency
   logic [127:0] core_pt = '0;
   logic [127:0] noise   = '0;
   int enc_run = 0;
   int dec_run = 0;
   int core_lat;

   always @(posedge clk) begin
      noise   <= rnd128();
      enc_run <= enc_en ? enc_run + 1 : 0;
      dec_run <= dec_en ? dec_run + 1 : 0;
   end

   assign core_lat = 12 + 2 * int'(core_sel);

   always_comb begin
      enc_out = (enc_run >= core_lat - 1) ? cipher(core_pt, core_sel) : noise;
      dec_out = (dec_run >= core_lat - 1) ? cipher(dec_in, core_sel) : noise;
   end

   task automatic drive_run(input logic [1:0] m, input logic [127:0] p, input logic [127:0] e,
                            input int abort_edge, input bit chg, output run_t r);
      int edges;
      int lat;
      lat = 12 + 2 * int'(m);
      r = '0;
      r.busy_ab = 1'b1;
      mode = m; pt = p; exp_ct = e; core_pt = p; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      edges = 0;
      while (edges < 80) begin
         if (abort_edge == edges + 1) abort = 1'b1;
         @(posedge clk); #1;
         edges++;
         abort = 1'b0;
         if (edges == abort_edge) r.busy_ab = busy | enc_en | dec_en;
         if (chg && edges == 3) begin
            mode = ~m; pt = rnd128(); exp_ct = rnd128();
         end
         if (edges == lat) begin
            r.ok_mid = enc_ok;
            r.rb_mid = result_byte;
         end
         if (edges == lat + 2) r.sel_mid = core_sel;
         if (done) break;
      end
      r.done_cyc = done ? edges + 1 : -1;
      @(posedge clk); #1;
      r.done_next = done;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      mode = 2'($urandom); pt = rnd128(); exp_ct = rnd128();
      #12;
      total++;
      if ({enc_en, dec_en, core_sel, dec_in, nr_out, busy, done, enc_ok, dec_ok, mode_err,
           pass_cnt, result_byte} !== '0) begin
         bad++;
         $display("[TB] FAIL reset_outputs: got busy=%b nr=%0d pass=%0d dec_in=%h, want all zero",
                  busy, nr_out, pass_cnt, dec_in);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      pass_model = 0;
   endtask

   task automatic test_vectors();
      run_t r;
      logic [127:0] ct;
      for (int m = 0; m < 3; m++) begin
         ct = vec_ct(2'(m));
         drive_run(2'(m), VEC_PT, ct, -1, 1'b0, r);
         pass_model++;
         total++;
         if (r.done_cyc !== 2 * (12 + 2 * m) + 1) begin
            bad++; $display("[TB] FAIL vec_done_cycle m=%0d: got %0d want %0d", m, r.done_cyc, 2 * (12 + 2 * m) + 1);
         end
         total++;
         if (r.ok_mid !== 1'b1 || r.rb_mid !== ct[127:120]) begin
            bad++; $display("[TB] FAIL vec_enc_capture m=%0d: got ok=%b byte=%h want ok=1 byte=%h", m, r.ok_mid, r.rb_mid, ct[127:120]);
         end
         total++;
         if ({enc_ok, dec_ok} !== 2'b11) begin
            bad++; $display("[TB] FAIL vec_flags m=%0d: got %b%b want 11", m, enc_ok, dec_ok);
         end
         total++;
         if (pass_cnt !== 8'(pass_model)) begin
            bad++; $display("[TB] FAIL vec_pass_cnt m=%0d: got %0d want %0d", m, pass_cnt, pass_model);
         end
         total++;
         if (nr_out !== 4'(10 + 2 * m) || core_sel !== 2'(m)) begin
            bad++; $display("[TB] FAIL vec_mode_latch m=%0d: got nr=%0d sel=%0d want nr=%0d sel=%0d", m, nr_out, core_sel, 10 + 2 * m, m);
         end
         total++;
         if (result_byte !== 8'h00 || dec_in !== ct) begin
            bad++; $display("[TB] FAIL vec_result m=%0d: got byte=%h dec_in=%h want 00 %h", m, result_byte, dec_in, ct);
         end
         total++;
         if (r.done_next !== 1'b0) begin
            bad++; $display("[TB] FAIL vec_done_width m=%0d: got done=%b one cycle later want 0", m, r.done_next);
         end
      end
   endtask

   task automatic test_bad_ct();
      run_t r;
      logic [127:0] ct;
      ct = vec_ct(2'd2) ^ 128'h1;
      drive_run(2'd2, VEC_PT, ct, -1, 1'b0, r);
      total++;
      if (r.done_cyc !== 33 || {enc_ok, dec_ok} !== 2'b01 || pass_cnt !== 8'(pass_model)) begin
         bad++; $display("[TB] FAIL bad_ct: got done_cyc=%0d flags=%b%b pass=%0d want 33 01 %0d",
                         r.done_cyc, enc_ok, dec_ok, pass_cnt, pass_model);
      end
   endtask

   task automatic test_mode_err();
      run_t r;
      logic [127:0] p;
      mode = 2'b11; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      total++;
      if (mode_err !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("[TB] FAIL mode_err_set: got err=%b busy=%b want 1 0", mode_err, busy);
      end
      repeat (3) @(posedge clk);
      #1;
      mode = 2'b00; start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      total++;
      if (mode_err !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("[TB] FAIL abort_beats_start: got err=%b busy=%b want 1 0", mode_err, busy);
      end
      p = rnd128();
      drive_run(2'd1, p, cipher(p, 2'd1), -1, 1'b0, r);
      pass_model++;
      total++;
      if (mode_err !== 1'b0 || r.done_cyc !== 29 || pass_cnt !== 8'(pass_model)) begin
         bad++; $display("[TB] FAIL mode_err_clear: got err=%b done_cyc=%0d pass=%0d want 0 29 %0d",
                         mode_err, r.done_cyc, pass_cnt, pass_model);
      end
   endtask

   task automatic test_abort();
      run_t r;
      logic [127:0] p;
      p = rnd128();
      drive_run(2'd1, p, cipher(p, 2'd1), 5, 1'b0, r);
      total++;
      if (r.done_cyc !== -1 || r.busy_ab !== 1'b0 || {enc_ok, dec_ok} !== 2'b00 || pass_cnt !== 8'(pass_model)) begin
         bad++; $display("[TB] FAIL abort_enc: got done_cyc=%0d busy=%b flags=%b%b pass=%0d want -1 0 00 %0d",
                         r.done_cyc, r.busy_ab, enc_ok, dec_ok, pass_cnt, pass_model);
      end
      p = rnd128();
      drive_run(2'd2, p, cipher(p, 2'd2), 19, 1'b0, r);
      total++;
      if (r.ok_mid !== 1'b1 || r.done_cyc !== -1 || r.busy_ab !== 1'b0 || {enc_ok, dec_ok} !== 2'b00) begin
         bad++; $display("[TB] FAIL abort_dec: got ok_mid=%b done_cyc=%0d busy=%b flags=%b%b want 1 -1 0 00",
                         r.ok_mid, r.done_cyc, r.busy_ab, enc_ok, dec_ok);
      end
      p = rnd128();
      drive_run(2'd0, p, cipher(p, 2'd0), -1, 1'b1, r);
      pass_model++;
      total++;
      if (r.sel_mid !== 2'd0 || nr_out !== 4'd10 || r.done_cyc !== 25) begin
         bad++; $display("[TB] FAIL midrun_mode_change: got sel=%0d nr=%0d done_cyc=%0d want 0 10 25",
                         r.sel_mid, nr_out, r.done_cyc);
      end
      total++;
      if ({enc_ok, dec_ok} !== 2'b11 || pass_cnt !== 8'(pass_model)) begin
         bad++; $display("[TB] FAIL midrun_input_change: got flags=%b%b pass=%0d want 11 %0d",
                         enc_ok, dec_ok, pass_cnt, pass_model);
      end
   endtask

   task automatic test_random();
      run_t r;
      logic [127:0] p, c, e;
      logic [1:0]   m;
      bit           flip;
      for (int i = 0; i < 8; i++) begin
         m = 2'($urandom_range(2, 0));
         p = rnd128();
         c = cipher(p, m);
         flip = 1'($urandom_range(1, 0));
         e = flip ? (c ^ (128'h1 << $urandom_range(127, 0))) : c;
         drive_run(m, p, e, -1, 1'b0, r);
         if (!flip) pass_model++;
         total++;
         if (r.done_cyc !== 2 * (12 + 2 * int'(m)) + 1 || r.rb_mid !== c[127:120]) begin
            bad++; $display("[TB] FAIL rand_timing i=%0d: got done_cyc=%0d byte=%h want %0d %h",
                            i, r.done_cyc, r.rb_mid, 2 * (12 + 2 * int'(m)) + 1, c[127:120]);
         end
         total++;
         if ({enc_ok, dec_ok} !== {!flip, 1'b1} || pass_cnt !== 8'(pass_model)) begin
            bad++; $display("[TB] FAIL rand_flags i=%0d: got flags=%b%b pass=%0d want %b1 %0d",
                            i, enc_ok, dec_ok, pass_cnt, !flip, pass_model);
         end
         total++;
         if (dec_in !== c || result_byte !== p[127:120]) begin
            bad++; $display("[TB] FAIL rand_result i=%0d: got dec_in=%h byte=%h want %h %h",
                            i, dec_in, result_byte, c, p[127:120]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] p;
      int edges, d1, d2;
      p = rnd128();
      mode = 2'd1; pt = p; exp_ct = cipher(p, 2'd1); core_pt = p; start = 1'b1;
      @(posedge clk); #1;
      edges = 0; d1 = -1; d2 = -1;
      while (edges < 150 && d2 < 0) begin
         if (done) begin
            if (d1 < 0) d1 = edges + 1;
            else        d2 = edges + 1;
         end
         if (d2 < 0) begin
            @(posedge clk); #1;
            edges++;
         end
      end
      start = 1'b0;
      @(posedge clk); #1;
      pass_model += 2;
      total++;
      if (d1 !== 29 || d2 !== 59) begin
         bad++; $display("[TB] FAIL back_to_back_timing: got done cycles %0d,%0d want 29,59", d1, d2);
      end
      total++;
      if (pass_cnt !== 8'(pass_model) || busy !== 1'b0) begin
         bad++; $display("[TB] FAIL back_to_back_count: got pass=%0d busy=%b want %0d 0", pass_cnt, busy, pass_model);
      end
   endtask

   task automatic test_reset_midrun();
      run_t r;
      mode = 2'd0; pt = VEC_PT; exp_ct = vec_ct(2'd0); core_pt = VEC_PT; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      total++;
      if ({enc_en, dec_en, core_sel, dec_in, nr_out, busy, done, enc_ok, dec_ok, mode_err,
           pass_cnt, result_byte} !== '0) begin
         bad++; $display("[TB] FAIL reset_midrun: got busy=%b dec_en=%b pass=%0d nr=%0d want all zero",
                         busy, dec_en, pass_cnt, nr_out);
      end
      pass_model = 0;
      #2;
      rst_n = 1'b1;
      drive_run(2'd0, VEC_PT, vec_ct(2'd0), -1, 1'b0, r);
      pass_model++;
      total++;
      if (r.done_cyc !== 25 || {enc_ok, dec_ok} !== 2'b11 || pass_cnt !== 8'(pass_model)) begin
         bad++; $display("[TB] FAIL after_reset_run: got done_cyc=%0d flags=%b%b pass=%0d want 25 11 %0d",
                         r.done_cyc, enc_ok, dec_ok, pass_cnt, pass_model);
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_bad_ct();
      test_mode_err();
      test_abort();
      test_random();
      test_back_to_back();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
